ram8_access_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares a single RAM8 register bank (eight 16-bit registers built from Bit/Register cells) between NUM_REQ requesters.
- Serialises read and write requests and drives the bank's `in`/`load`/`address` pins.
- Captures the bank's `out` for reads and returns a one-cycle `ack` to the winning requester.
- Sits between the CPU-side masters (CPU data port, debug/loader port, etc.) and the RAM8 instance.

---
 rtl/ram8_access_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram8_access_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_access_arbiter.sv
// ram8_access_arbiter
//
// Shares one RAM8 register bank (eight DATA_W-bit registers) between NUM_REQ
// requesters. Requests are serialised by a three-state sequencer
// (IDLE -> ACCESS -> RESP). The winner's address, data and write enable drive
// the bank pins for exactly one cycle (ACCESS). A read captures the bank
// output on the edge that leaves ACCESS. A one-cycle ack is then returned in
// RESP.
//
// Build option:
//   RAM8_ARB_FIXED_PRIO_EN - when defined, arbitration is fixed priority
//                            (requester 0 highest) and the round-robin
//                            pointer is removed. Timing is unchanged.
//                            When undefined, arbitration is round robin.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   req         in   [NUM_REQ] request per requester, held until its ack
//   we          in   [NUM_REQ] write enable per requester, sampled at grant
//   addr        in   [NUM_REQ*ADDR_W] flattened addresses, slice i*ADDR_W
//   wdata       in   [NUM_REQ*DATA_W] flattened write data, slice i*DATA_W
//   ack         out  [NUM_REQ] one-hot, one-cycle completion pulse
//   rd_data     out  [DATA_W] last read result, held between reads
//   busy        out  high in ACCESS and RESP
//   grant_id    out  [ID_W] index of the current/last winner
//   ram_in      out  [DATA_W] to RAM8 in
//   ram_load    out  to RAM8 load
//   ram_address out  [ADDR_W] to RAM8 address
//   ram_out     in   [DATA_W] from RAM8 out (combinational read)

module ram8_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [DATA_W-1:0]         ram_in,
    output logic                      ram_load,
    output logic [ADDR_W-1:0]         ram_address,
    input  logic [DATA_W-1:0]         ram_out
);

    // Internal index width: just wide enough to name every requester.
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]         state_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               busy_q;
    logic [DATA_W-1:0]  ram_in_q;
    logic               ram_load_q;
    logic [ADDR_W-1:0]  ram_address_q;

`ifndef RAM8_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_next;
`endif

    // Unpack the flattened request buses so the winner can index them.
    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    end

    // Winner selection: scan from the start point and take the first set bit.
    logic             any_req;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] sel;
    int unsigned      idx;

    always_comb begin
        any_req = 1'b0;
        win     = '0;
        sel     = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef RAM8_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = 32'(rr_ptr_q) + i;
            if (idx >= 32'(NUM_REQ)) begin
                idx = idx - 32'(NUM_REQ);
            end
`endif
            sel = idx[IDX_W-1:0];
            if (!any_req && req[sel]) begin
                any_req = 1'b1;
                win     = sel;
            end
        end
    end

`ifndef RAM8_ARB_FIXED_PRIO_EN
    // The pointer moves one past the last winner, so that winner has lowest
    // priority next time. It wraps explicitly for non-power-of-two NUM_REQ.
    always_comb begin
        if (gnt_q == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = gnt_q + IDX_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            ack_q         <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            ram_in_q      <= '0;
            ram_load_q    <= 1'b0;
            ram_address_q <= '0;
`ifndef RAM8_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    ram_load_q <= 1'b0;
                    if (any_req) begin
                        gnt_q         <= win;
                        ram_address_q <= addr_a[win];
                        ram_in_q      <= wdata_a[win];
                        ram_load_q    <= we[win];
                        busy_q        <= 1'b1;
                        state_q       <= ACCESS;
                    end
                end

                ACCESS: begin
                    // ram_load_q still holds the latched write enable here,
                    // so it doubles as the read/write flag.
                    ram_load_q <= 1'b0;
                    if (!ram_load_q) begin
                        rd_data_q <= ram_out;
                    end
                    ack_q[gnt_q] <= 1'b1;
                    state_q      <= RESP;
                end

                RESP: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifndef RAM8_ARB_FIXED_PRIO_EN
                    rr_ptr_q <= rr_ptr_next;
`endif
                end

                default: begin
                    ack_q      <= '0;
                    busy_q     <= 1'b0;
                    ram_load_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign grant_id    = ID_W'(gnt_q);
    assign ram_in      = ram_in_q;
    assign ram_address = ram_address_q;
    // The bank commits on the same edge that reset is sampled. Masking load
    // with reset keeps a write caught in ACCESS from landing.
    assign ram_load    = ram_load_q & ~reset;

endmodule

// File: tb/tb_ram8_access_arbiter.sv
// Self-checking bench for ram8_access_arbiter with a behavioural RAM8 model.
module tb_ram8_access_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic [DATA_W-1:0]         ram_in;
    logic                      ram_load;
    logic [ADDR_W-1:0]         ram_address;
    logic [DATA_W-1:0]         ram_out;

    ram8_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rd_data     (rd_data),
        .busy        (busy),
        .grant_id    (grant_id),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_out     (ram_out)
    );

    always #5 clk = ~clk;

    // RAM8 model: write on rising edge when load is high, combinational read.
    logic [DATA_W-1:0] mem [8];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic [DATA_W-1:0]  rd;
        logic [ID_W-1:0]    gid;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_rd  = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        we    = '0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        last_rd = 16'h0000;
    endtask

    task automatic drive(input int r, input bit w, input logic [2:0] a, input logic [15:0] d);
        req[r]               = 1'b1;
        we[r]                = w;
        addr[r*ADDR_W +: 3]  = a;
        wdata[r*DATA_W +: 16] = d;
    endtask

    // Single uncontended transaction; called at a negedge with the DUT idle.
    task automatic txn(input int r, input bit w, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input bit drop);
        exp_t e;
        int   n;
        e.ack = 4'b0001 << r;
        e.rd  = exp_rd;
        e.gid = r[1:0];
        sb.push_back(e);
        drive(r, w, a, d);
        @(negedge clk);
        chk("access_busy", busy, 1);
        chk("access_load", ram_load, w);
        chk("access_addr", ram_address, a);
        if (w) chk("access_in", ram_in, d);
        chk("access_noack", ack, 0);
        chk("access_rd_hold", rd_data, last_rd);
        if (drop) req[r] = 1'b0;
        n = 1;
        while (ack == '0 && n < 6) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk("ack", ack, e.ack);
        chk("ack_latency", n, 2);
        chk("rd_data", rd_data, e.rd);
        chk("grant_id", grant_id, e.gid);
        chk("resp_load", ram_load, 0);
        chk("resp_busy", busy, 1);
        req[r] = 1'b0;
        we[r]  = 1'b0;
        last_rd = e.rd;
        @(negedge clk);
        chk("idle_ack", ack, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rd_hold", rd_data, last_rd);
    endtask

    initial begin
        int   t;
        int   last_t;
        exp_t e;
        logic [ID_W-1:0] gseq [5];

        foreach (mem[i]) mem[i] = '0;
        addr  = '0;
        wdata = '0;

        // Reset state
        do_reset();
        chk("rst_ack", ack, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_ram_in", ram_in, 0);
        chk("rst_ram_load", ram_load, 0);
        chk("rst_ram_address", ram_address, 0);

        // Write then read back through the bank
        txn(0, 1'b1, 3'd5, 16'h1234, 16'h0000, 1'b0);
        txn(1, 1'b0, 3'd5, 16'h0000, 16'h1234, 1'b0);

        // Idle cycles leave rd_data alone
        repeat (3) @(negedge clk);
        chk("idle_hold", rd_data, 16'h1234);

        // All requesters held high: rotation and 3-cycle throughput
        do_reset();
`ifdef RAM8_ARB_FIXED_PRIO_EN
        gseq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        gseq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        for (int k = 0; k < 5; k++) begin
            e.gid = gseq[k];
            e.ack = 4'b0001 << gseq[k];
            e.rd  = 16'h1234;
            sb.push_back(e);
        end
        for (int r = 0; r < NUM_REQ; r++) drive(r, 1'b0, 3'd5, 16'h0);
        t      = 0;
        last_t = 0;
        for (int k = 0; k < 5; k++) begin
            do begin
                @(negedge clk);
                t++;
            end while (ack == '0 && t < last_t + 8);
            e = sb.pop_front();
            chk("rr_ack", ack, e.ack);
            chk("rr_grant_id", grant_id, e.gid);
            chk("rr_rd_data", rd_data, e.rd);
            if (k == 0) chk("rr_first_latency", t, 2);
            else        chk("rr_spacing", t - last_t, 3);
            last_t = t;
            if (k == 4) req = '0;
        end
        @(negedge clk);
        chk("rr_end_busy", busy, 0);
        last_rd = 16'h1234;

        // Reset during ACCESS kills an in-flight write
        do_reset();
        drive(2, 1'b1, 3'd7, 16'hBEEF);
        @(negedge clk);
        chk("rstmid_access_load", ram_load, 1);
        chk("rstmid_access_busy", busy, 1);
        reset = 1'b1;
        req   = '0;
        we    = '0;
        @(negedge clk);
        chk("rstmid_ack", ack, 0);
        chk("rstmid_load", ram_load, 0);
        chk("rstmid_busy", busy, 0);
        reset   = 1'b0;
        last_rd = 16'h0000;
        txn(0, 1'b0, 3'd7, 16'h0000, 16'h0000, 1'b0);

        // Requester 3 drops req during ACCESS; transaction still completes
        txn(3, 1'b0, 3'd5, 16'h0000, 16'h1234, 1'b1);

        // Write leaves rd_data unchanged; the next read replaces it
        txn(0, 1'b1, 3'd2, 16'h5A5A, 16'h1234, 1'b0);
        txn(1, 1'b0, 3'd2, 16'h0000, 16'h5A5A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
